// File: rtl/gon_drain_controller_if.sv
// Bus bundle for one drain controller: the X-bus poll/response pair and
// the valid/ready output stream toward the GLB write port.
interface gon_drain_controller_if #(
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 32
);
  logic [ID_LEN:0]      ready_tag;
  logic [VALUE_LEN:0]   enable_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [VALUE_LEN-1:0] out_data;
  logic [ID_LEN-1:0]    out_tag;

  modport master (
    output ready_tag,
    input  enable_value,
    output out_valid,
    output out_data,
    output out_tag,
    input  out_ready
  );

  modport slave (
    input  ready_tag,
    output enable_value,
    input  out_valid,
    input  out_data,
    input  out_tag,
    output out_ready
  );
endinterface

// File: rtl/gon_drain_controller.sv
// Walks a contiguous tag range on one GON X-bus, capturing each returned value
// into a small FIFO that feeds the GLB write port.
module gon_drain_controller #(
  parameter int ID_LEN     = 5,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ID_LEN-1:0]   tag_base,
  input  logic [ID_LEN:0]     tag_count,
  output logic                busy,
  output logic                done,
  gon_drain_controller_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, POLL, DRAIN} state_t;

  state_t                       state_reg, state_next;
  logic [ID_LEN-1:0]            cur_tag_reg, cur_tag_next;
  logic [ID_LEN:0]              remaining_reg, remaining_next;
  logic                         done_reg, done_next;
  logic [PTR_W-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]             count_reg;
  logic [ID_LEN+VALUE_LEN-1:0]  mem [FIFO_DEPTH];
  logic [ID_LEN+VALUE_LEN-1:0]  head;
  logic                         poll_ready;
  logic                         capture;
  logic                         pop;
  logic                         fifo_valid;

  // Ready comes only from flops so the bus response can never loop back into it.
  assign poll_ready = (state_reg == POLL) && (count_reg != FULL_CNT);
  assign capture    = poll_ready && bus.enable_value[VALUE_LEN];
  assign fifo_valid = (count_reg != '0);
  assign pop        = fifo_valid && bus.out_ready;
  assign head       = mem[rd_ptr_reg];

  assign bus.ready_tag = (state_reg == POLL) ? {poll_ready, cur_tag_reg} : '0;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_valid ? head[VALUE_LEN-1:0] : '0;
  assign bus.out_tag   = fifo_valid ? head[ID_LEN+VALUE_LEN-1:VALUE_LEN] : '0;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;

  always_comb begin
    state_next     = state_reg;
    cur_tag_next   = cur_tag_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cur_tag_next   = tag_base;
          remaining_next = tag_count;
          state_next     = (tag_count != '0) ? POLL : DRAIN;
        end
      end
      POLL: begin
        if (capture) begin
          cur_tag_next   = cur_tag_reg + ID_LEN'(1);
          remaining_next = remaining_reg - (ID_LEN+1)'(1);
          if (remaining_reg == (ID_LEN+1)'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!fifo_valid) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cur_tag_reg   <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_tag_reg   <= cur_tag_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (capture) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({capture, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; outputs are masked by the occupancy count instead.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_reg] <= {cur_tag_reg, bus.enable_value[VALUE_LEN-1:0]};
    end
  end
endmodule

// File: tb/tb_gon_drain_controller.sv
// Directed scenarios with a queue-based scoreboard checked by an independent output monitor.
module tb_gon_drain_controller;
  localparam int ID_LEN     = 5;
  localparam int VALUE_LEN  = 32;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [ID_LEN-1:0]   tag_base = '0;
  logic [ID_LEN:0]     tag_count = '0;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  gon_drain_controller_if #(.ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN)) bus ();

  gon_drain_controller #(
    .ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tag_base(tag_base),
    .tag_count(tag_count), .busy(busy), .done(done), .bus(bus.master)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int en_mode = 0;          // 0: never respond, 1: always, 2: every 3rd cycle
  int n_capt = 0;
  int n_done = 0;
  logic [ID_LEN+VALUE_LEN-1:0] exp_q[$];
  int pop_cyc[$];
  logic prev_ready = 1'b0;
  logic prev_en = 1'b0;
  logic [ID_LEN:0] prev_rt = '0;
  logic en;

  // Bus model: a PE owning the polled tag answers with 0x100 + tag.
  always_comb begin
    en = (en_mode == 1) || ((en_mode == 2) && (cyc % 3 == 0));
    bus.enable_value = {en, VALUE_LEN'(32'h100) + VALUE_LEN'(bus.ready_tag[ID_LEN-1:0])};
  end

  initial bus.out_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboard on each output handshake, tracks captures and done.
  always @(negedge clk) begin
    if (!rst) begin
      prev_ready = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {bus.out_tag, bus.out_data}, 64'hDEAD);
        end else begin
          logic [ID_LEN+VALUE_LEN-1:0] e;
          e = exp_q.pop_front();
          check("out_tag_data", {bus.out_tag, bus.out_data}, e);
          $display("pop tag=%0d data=%0h", bus.out_tag, bus.out_data);
        end
      end
      if (prev_ready && !prev_en && busy)
        check("tag_hold", bus.ready_tag, prev_rt);
      if (bus.ready_tag[ID_LEN] && bus.enable_value[VALUE_LEN]) n_capt++;
      if (done) begin
        n_done++;
        check("busy_low_at_done", busy, 1'b0);
      end
      prev_ready = bus.ready_tag[ID_LEN];
      prev_en    = bus.enable_value[VALUE_LEN];
      prev_rt    = bus.ready_tag;
    end
  end

  task automatic push_exp(input logic [ID_LEN-1:0] base, input int count);
    logic [ID_LEN-1:0] t;
    for (int i = 0; i < count; i++) begin
      t = base + ID_LEN'(i);
      exp_q.push_back({t, VALUE_LEN'(32'h100) + VALUE_LEN'(t)});
    end
  endtask

  task automatic do_start(input logic [ID_LEN-1:0] base, input logic [ID_LEN:0] count);
    @(posedge clk); #1;
    start = 1'b1; tag_base = base; tag_count = count;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic basic_drain(input string tag);
    en_mode = 1; bus.out_ready = 1'b1; n_done = 0;
    pop_cyc.delete();
    push_exp(5'd3, 4);
    do_start(5'd3, 6'd4);
    check({tag, "_busy_rise"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_first_tag"}, bus.ready_tag, 6'h23);
    @(negedge clk);
    check({tag, "_next_tag"}, bus.ready_tag, 6'h24);
    wait_done(50);
    check({tag, "_pops"}, pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) check({tag, "_consecutive"}, pop_cyc[3] - pop_cyc[0], 3);
    check({tag, "_single_done"}, n_done, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready_tag", bus.ready_tag, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", {bus.out_tag, bus.out_data}, '0);
    @(posedge clk); #1 rst = 1'b1;

    basic_drain("basic");

    // Backpressure: FIFO fills after 4 captures and the tag stalls at 4.
    en_mode = 1; bus.out_ready = 1'b0; n_capt = 0;
    push_exp(5'd0, 8);
    do_start(5'd0, 6'd8);
    repeat (19) @(negedge clk);
    check("bp_captures", n_capt, 4);
    check("bp_ready_tag", bus.ready_tag, 6'h04);
    check("bp_out_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(60);
    check("bp_total_captures", n_capt, 8);
    check("bp_queue_empty", exp_q.size(), 0);

    // Sparse responder.
    en_mode = 2; n_capt = 0;
    push_exp(5'd10, 5);
    do_start(5'd10, 6'd5);
    wait_done(100);
    check("sparse_captures", n_capt, 5);
    check("sparse_queue_empty", exp_q.size(), 0);

    // Tag wrap 30,31,0,1.
    en_mode = 1;
    push_exp(5'd30, 4);
    do_start(5'd30, 6'd4);
    wait_done(50);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Zero count: done two cycles after start, no polling.
    n_capt = 0;
    do_start(5'd7, 6'd0);
    check("zero_ready_tag", bus.ready_tag, '0);
    @(negedge clk);
    check("zero_done_early", done, 1'b0);
    @(negedge clk);
    check("zero_done_at_2", done, 1'b1);
    check("zero_captures", n_capt, 0);

    // Full 32-tag range.
    n_capt = 0;
    push_exp(5'd0, 32);
    do_start(5'd0, 6'd32);
    wait_done(200);
    check("full_captures", n_capt, 32);
    check("full_queue_empty", exp_q.size(), 0);

    // Start while busy is ignored.
    en_mode = 2; n_done = 0;
    push_exp(5'd20, 6);
    do_start(5'd20, 6'd6);
    repeat (3) @(negedge clk);
    do_start(5'd9, 6'd5);
    wait_done(100);
    repeat (3) @(negedge clk);
    check("busy_start_single_done", n_done, 1);
    check("busy_start_stays_idle", busy, 1'b0);
    check("busy_start_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-drain.
    en_mode = 1; bus.out_ready = 1'b0; n_done = 0;
    do_start(5'd0, 6'd8);
    repeat (3) @(negedge clk);
    check("mid_valid_before_rst", bus.out_valid, 1'b1);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ready_tag", bus.ready_tag, '0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_idle", busy, 1'b0);

    basic_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
